lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Initiator side of the data-memory port: takes one load/store request at a time from the pipeline and drives the word-addressed data RAM (write enable, byte address, write data in; read data out, combinational, word-aligned).
- Provides RV32I byte/halfword/word loads with sign/zero extension.
- Builds sub-word stores as read-modify-write, because the RAM only supports full-word writes.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width driven to memory.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (IDLE only).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the value is in the low bits for B and H.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result after extension; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal funct3, valid only with rsp_valid.
- mem_we  out  1  RAM write enable.
- mem_A  out  ADDR_W  RAM byte address, always {addr_q[ADDR_W-1:2],2'b00}.
- mem_WD  out  32  RAM write data; 0 whenever mem_we=0.
- mem_RD  in  32  RAM read data, combinational from mem_A.

Behaviour:
- Reset:
  - Reset is synchronous; rst=1 at a rising edge forces IDLE from any state.
  - Any in-flight request is dropped: no rsp_valid and no further mem_we.
  - All outputs are 0 after reset except req_ready=1. addr_q, wdata_q and merge_q reset to 0.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr_q, wdata_q, we_q and f3_q.
  - Next state is RESP if the request is an error, otherwise ACCESS.
- Error rules:
  - Illegal funct3 for loads: 011, 110, 111.
  - Illegal funct3 for stores: anything other than 000, 001, 010.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- ACCESS:
  - mem_A is driven from addr_q.
  - Load: mem_RD is sampled and extended into rsp_rdata_q. Next state RESP.
    - Byte lane = addr_q[1:0]; halfword lane = addr_q[1].
    - B and H sign-extend; BU and HU zero-extend.
  - SW: mem_we=1 and mem_WD=wdata_q this cycle. Next state RESP.
  - SB/SH: merge_q = mem_RD with the target lane replaced by wdata_q[7:0] or wdata_q[15:0]. Next state WRITE.
- WRITE:
  - mem_we=1, mem_WD=merge_q, mem_A unchanged. Next state RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, together with rsp_rdata and rsp_err. Next state IDLE.
- Latency from the accepting edge to rsp_valid high:
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Throughput:
  - One request per response. The next request can be accepted in the IDLE cycle after RESP.
  - req_valid outside IDLE is ignored.
- mem_we is never high in IDLE or RESP. Exactly one write cycle per legal store; zero for loads and errors.
- rsp_rdata is held from RESP until the next response.

Test Plan:
- Word store then load:
  - Stimulus: SW addr 0x10 data 0xDEADBEEF, then LW 0x10.
  - Required: mem_we high for exactly one cycle with mem_A=0x10; response 2 cycles after accept with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Sub-word loads, with word 0x80F17F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80.
  - LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80F1.
  - LHU 0x20 -> 0x00007F01.
  - LB 0x20 -> 0x00000001.
- Read-modify-write stores, with word 0x11223344 at 0x30:
  - SB 0x31 data 0xAA -> one ACCESS read, then one WRITE of 0x1122AA44. Response 3 cycles after accept.
  - SH 0x32 data 0xBEEF -> 0xBEEFAA44.
- Errors:
  - LW 0x41, SH 0x43, and load funct3=011 -> rsp_err=1 one cycle after accept, rsp_rdata=0, mem_we never asserted, RAM unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during WRITE of an SB.
  - Required: no mem_we on the following cycles and no rsp_valid; req_ready=1 after reset; the target word still holds its old value.
- Back-to-back requests:
  - Stimulus: req_valid held high continuously with 3 loads.
  - Required: req_ready low from ACCESS through RESP; exactly 3 rsp_valid pulses in order; req_valid outside IDLE is ignored (no extra captures).

Source files
------------

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: one load/store at a time, RV32I extension on loads,
// read-modify-write for sub-word stores into a word-only RAM.
module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  input  logic [31:0]       mem_RD
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              err_q;

  logic              bad_f3;
  logic              misal;
  logic              req_err;
  logic              is_sw;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext_v;
  logic [31:0]       merge_v;

  always_comb begin
    if (req_we)
      bad_f3 = (req_funct3 > 3'b010);
    else
      bad_f3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
         || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = bad_f3 || misal;
  end

  assign is_sw = we_q && (f3_q == 3'b010);

  always_comb begin
    unique case (addr_q[1:0])
      2'd0: byte_v = mem_RD[7:0];
      2'd1: byte_v = mem_RD[15:8];
      2'd2: byte_v = mem_RD[23:16];
      default: byte_v = mem_RD[31:24];
    endcase
    half_v = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    unique case (f3_q)
      3'b000: ext_v = {{24{byte_v[7]}}, byte_v};
      3'b100: ext_v = {24'd0, byte_v};
      3'b001: ext_v = {{16{half_v[15]}}, half_v};
      3'b101: ext_v = {16'd0, half_v};
      default: ext_v = mem_RD;
    endcase
  end

  // Splice the store lane into the word just read.
  always_comb begin
    merge_v = mem_RD;
    if (f3_q[0])
      merge_v[{addr_q[1], 4'd0} +: 16] = wdata_q[15:0];
    else
      merge_v[{addr_q[1:0], 3'd0} +: 8] = wdata_q[7:0];
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = (state == S_RESP) && err_q;
  assign rsp_rdata = rdata_q;
  assign mem_A     = {addr_q[ADDR_W-1:2], 2'b00};

  // Gated by rst so a reset during WRITE never commits the pending word.
  assign mem_we = !rst && (((state == S_ACCESS) && is_sw)
                         || (state == S_WRITE));
  assign mem_WD = !mem_we ? 32'd0
                : (state == S_WRITE) ? merge_q : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            f3_q    <= req_funct3;
            err_q   <= req_err;
            if (req_err) begin
              rdata_q <= '0;
              state   <= S_RESP;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!we_q) begin
            rdata_q <= ext_v;
            state   <= S_RESP;
          end else if (is_sw) begin
            rdata_q <= '0;
            state   <= S_RESP;
          end else begin
            merge_q <= merge_v;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          rdata_q <= '0;
          state   <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
